// File: rtl/is_prime_pkg.sv
// Shared types and helpers for the is_prime engine arbiter.
package is_prime_pkg;

  localparam int DEFAULT_VALUE_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HIT   = 2'd3
  } arb_state_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/is_prime_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or above ptr, else lowest overall.
module rr_pick
  import is_prime_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  // Two passes: upper window first, then wrap around to the bottom.
  always_comb begin
    grant = {NUM_REQ{1'b0}};
    idx   = {IDX_W{1'b0}};
    any   = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!any && req[j] && (IDX_W'(j) >= ptr)) begin
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
        any      = 1'b1;
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!any && req[j]) begin
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/is_prime_arbiter.sv
// Round-robin arbiter sharing one is_prime engine between NUM_REQ requesters.
// Define IS_PRIME_ARB_CACHE_EN to add a one-entry result cache (HIT state).
module is_prime_arbiter
  import is_prime_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int VALUE_W = DEFAULT_VALUE_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*VALUE_W-1:0] req_value,
  output logic [NUM_REQ-1:0]         ack,
  output logic                       rsp_prime,
  output logic                       eng_start,
  output logic [VALUE_W-1:0]         eng_value,
  input  logic                       eng_result,
  input  logic                       eng_done
);

  localparam int IDX_W = idx_w(NUM_REQ);

  arb_state_t           state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   win_q, win_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 rsp_q, rsp_d;
  logic                 start_q, start_d;
  logic [VALUE_W-1:0]   value_q, value_d;
  logic                 prev_done_q;

  logic [NUM_REQ-1:0]   pick_grant;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;
  logic [VALUE_W-1:0]   pick_value;
  logic [IDX_W-1:0]     ptr_next;
  logic                 done_rise;

`ifdef IS_PRIME_ARB_CACHE_EN
  logic                 cache_valid_q, cache_valid_d;
  logic [VALUE_W-1:0]   cache_value_q, cache_value_d;
  logic                 cache_result_q, cache_result_d;
`endif

  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr_pick (
    .req   (req),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Winner operand mux and pointer increment.
  always_comb begin
    pick_value = {VALUE_W{1'b0}};
    for (int j = 0; j < NUM_REQ; j++) begin
      if (pick_grant[j]) begin
        pick_value = req_value[j*VALUE_W +: VALUE_W];
      end
    end
    if (pick_idx == IDX_W'(NUM_REQ - 1)) begin
      ptr_next = {IDX_W{1'b0}};
    end else begin
      ptr_next = pick_idx + {{(IDX_W-1){1'b0}}, 1'b1};
    end
  end

  assign done_rise = eng_done && !prev_done_q;

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    ack_d   = {NUM_REQ{1'b0}};
    rsp_d   = rsp_q;
    start_d = start_q;
    value_d = value_q;
`ifdef IS_PRIME_ARB_CACHE_EN
    cache_valid_d  = cache_valid_q;
    cache_value_d  = cache_value_q;
    cache_result_d = cache_result_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          win_d = pick_grant;
          ptr_d = ptr_next;
`ifdef IS_PRIME_ARB_CACHE_EN
          if (cache_valid_q && (cache_value_q == pick_value)) begin
            state_d = HIT;
          end else begin
            value_d = pick_value;
            start_d = 1'b1;
            state_d = RUN;
          end
`else
          value_d = pick_value;
          start_d = 1'b1;
          state_d = RUN;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (done_rise) begin
          ack_d   = win_q;
          rsp_d   = eng_result;
          start_d = 1'b0;
          state_d = DRAIN;
`ifdef IS_PRIME_ARB_CACHE_EN
          cache_valid_d  = 1'b1;
          cache_value_d  = value_q;
          cache_result_d = eng_result;
`endif
        end else begin
          state_d = RUN;
        end
      end
      // A done level left over from the last job must clear before a new start.
      DRAIN: begin
        if (!eng_done) begin
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      HIT: begin
`ifdef IS_PRIME_ARB_CACHE_EN
        ack_d = win_q;
        rsp_d = cache_result_q;
`endif
        state_d = IDLE;
      end
      default: begin
        start_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= {IDX_W{1'b0}};
      win_q       <= {NUM_REQ{1'b0}};
      ack_q       <= {NUM_REQ{1'b0}};
      rsp_q       <= 1'b0;
      start_q     <= 1'b0;
      value_q     <= {VALUE_W{1'b0}};
      prev_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      ack_q       <= ack_d;
      rsp_q       <= rsp_d;
      start_q     <= start_d;
      value_q     <= value_d;
      prev_done_q <= eng_done;
    end
  end

`ifdef IS_PRIME_ARB_CACHE_EN
  // Single-entry verdict cache.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_valid_q  <= 1'b0;
      cache_value_q  <= {VALUE_W{1'b0}};
      cache_result_q <= 1'b0;
    end else begin
      cache_valid_q  <= cache_valid_d;
      cache_value_q  <= cache_value_d;
      cache_result_q <= cache_result_d;
    end
  end
`endif

  assign ack       = ack_q;
  assign rsp_prime = rsp_q;
  assign eng_start = start_q;
  assign eng_value = value_q;

endmodule
